// File: rtl/harvard_data_memory.sv
// Single-port 256 x 16 data memory behind the Harvard processor's data port.
// A sequential dump engine can stream the whole array out after the program halts.
// A processor access always has priority over the dump for the one array port.
module harvard_data_memory #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MAR_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clk_md,
    input  logic              wren,
    input  logic [MAR_W-1:0]  mar,
    input  logic [DATA_W-1:0] mbr,
    output logic [DATA_W-1:0] out_md,
    output logic              addr_err,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } dump_state_e;

    logic [DATA_W-1:0] mem [Depth];

    logic              clk_md_q;
    logic [DATA_W-1:0] out_md_q, out_md_d;
    logic              addr_err_q, addr_err_d;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;

    logic              access;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // One access per rising edge of the strobe, however long it stays high.
    assign access    = clk_md & ~clk_md_q;
    assign in_range  = (mar[MAR_W-1:ADDR_W] == '0);
    // The single array port goes to the processor whenever it accesses, else to the dump.
    assign mem_addr  = access ? mar[ADDR_W-1:0] : ptr_q;
    assign mem_rdata = mem[mem_addr];
    assign mem_we    = access & wren & in_range;

    // Array write; contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mbr;
        end
    end

    // Processor read data and the sticky out-of-range flag.
    always_comb begin
        out_md_d   = out_md_q;
        addr_err_d = addr_err_q;
        if (access) begin
            if (!in_range) begin
                addr_err_d = 1'b1;
            end
            if (!wren) begin
                out_md_d = in_range ? mem_rdata : '0;
            end
        end
    end

    // Dump engine next state; a processor access stalls it for that cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        // Busy covers RUN and the DONE cycle itself, so it falls only once back in IDLE.
        busy_d  = (state_q != StIdle) | dump_start;
        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    state_d = StRun;
                    ptr_d   = '0;
                end
            end
            StRun: begin
                if (!access) begin
                    valid_d = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = mem_rdata;
                    // Stop on the last word instead of wrapping into a second pass.
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_d = StDone;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any dump in progress without a done pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_md_q   <= 1'b0;
            out_md_q   <= '0;
            addr_err_q <= 1'b0;
            state_q    <= StIdle;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            clk_md_q   <= clk_md;
            out_md_q   <= out_md_d;
            addr_err_q <= addr_err_d;
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign out_md     = out_md_q;
    assign addr_err   = addr_err_q;
    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;
    assign dump_done  = done_q;

endmodule
